// File: rtl/dram_arbiter.sv
// Round-robin arbiter that serialises CPU and DMA accesses onto a single-port DRAM.
// One transaction at a time: IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> DONE -> IDLE.
module dram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] dram_addr,
  output logic              dram_we,
  output logic [DATA_W-1:0] dram_din,
  input  logic [DATA_W-1:0] dram_dout,
  output logic              busy,
  output logic              owner_dma
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it until its
  // one-cycle ack; any req seen high in IDLE starts a new transaction. Request fields are
  // latched at grant, so later input changes (including dropping req) do not affect it.

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_dma_q, last_dma_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic grant_cpu;
  logic grant_dma;

  // On conflict the side that did not win last time goes first.
  assign grant_dma = dma_req && (!cpu_req || !last_dma_q);
  assign grant_cpu = cpu_req && (!dma_req || last_dma_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_dma_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_dma_q  <= last_dma_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_dma_d  = last_dma_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_dma) begin
          owner_d    = 1'b1;
          last_dma_d = 1'b1;
          we_d       = dma_we;
          addr_d     = dma_addr;
          wdata_d    = dma_wdata;
          state_d    = S_ACCESS;
        end else if (grant_cpu) begin
          owner_d    = 1'b0;
          last_dma_d = 1'b0;
          we_d       = cpu_we;
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle: dram_dout now reflects the address presented in ACCESS.
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q) begin
            dma_rdata_d = dram_dout;
          end else begin
            cpu_rdata_d = dram_dout;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    dram_we = (state_q == S_ACCESS) && we_q;
    cpu_ack = (state_q == S_DONE) && !owner_q;
    dma_ack = (state_q == S_DONE) && owner_q;
  end

  // Address and data come straight from the latch so they hold their value through IDLE.
  assign dram_addr = addr_q;
  assign dram_din  = wdata_q;
  assign owner_dma = owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: table of single transactions plus hand-written
// sequences for conflicts, continuous requests, reset mid-read and mid-transaction changes.
module tb_dram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] dram_addr;
  logic              dram_we;
  logic [DATA_W-1:0] dram_din, dram_dout;
  logic              busy, owner_dma;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_q[$];
  logic              grant_log[$];
  logic [DATA_W-1:0] cpu_rd_exp, dma_rd_exp;

  typedef struct {
    bit                dma;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  vec_t vecs[9];

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dram_addr(dram_addr), .dram_we(dram_we), .dram_din(dram_din), .dram_dout(dram_dout),
    .busy(busy), .owner_dma(owner_dma)
  );

  // Clock / DRAM model (single-cycle read latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dram_we) mem[dram_addr] <= dram_din;
    dram_dout <= mem[dram_addr];
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, required finished)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s_cpu_ack", tag), cpu_ack, 0);
    check($sformatf("%s_dma_ack", tag), dma_ack, 0);
    check($sformatf("%s_cpu_rdata", tag), cpu_rdata, 0);
    check($sformatf("%s_dma_rdata", tag), dma_rdata, 0);
    check($sformatf("%s_dram_addr", tag), dram_addr, 0);
    check($sformatf("%s_dram_we", tag), dram_we, 0);
    check($sformatf("%s_dram_din", tag), dram_din, 0);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_owner", tag), owner_dma, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cpu_rd_exp = '0;
    dma_rd_exp = '0;
  endtask

  // Driver: one isolated transaction, starting and ending on a negedge.
  task automatic run_single(input vec_t v, input string tag);
    int ack_cyc, we_n, we_first, foreign_n;
    logic [DATA_W-1:0] exp_rd;
    ack_cyc = -1; we_n = 0; we_first = -1; foreign_n = 0;
    if (v.dma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    if (!v.we) exp_q.push_back(v.rdata);
    for (int c = 1; c <= 12 && ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check($sformatf("%s_busy", tag), busy, 1);
        check($sformatf("%s_owner", tag), owner_dma, v.dma);
        check($sformatf("%s_addr", tag), dram_addr, v.addr);
        if (v.we) check($sformatf("%s_din", tag), dram_din, v.wdata);
      end
      if (dram_we) begin
        we_n++;
        if (we_first < 0) we_first = c;
      end
      if (v.dma ? cpu_ack : dma_ack) foreign_n++;
      if (v.dma ? dma_ack : cpu_ack) ack_cyc = c;
    end
    check($sformatf("%s_latency", tag), ack_cyc, v.we ? 2 : 2 + RD_LAT);
    check($sformatf("%s_we_cycles", tag), we_n, v.we ? 1 : 0);
    if (v.we) check($sformatf("%s_we_cycle", tag), we_first, 1);
    check($sformatf("%s_foreign_ack", tag), foreign_n, 0);
    if (!v.we) begin
      exp_rd = exp_q.pop_front();
      if (v.dma) dma_rd_exp = exp_rd;
      else cpu_rd_exp = exp_rd;
    end
    check($sformatf("%s_cpu_rdata", tag), cpu_rdata, cpu_rd_exp);
    check($sformatf("%s_dma_rdata", tag), dma_rdata, dma_rd_exp);
    if (v.dma) dma_req = 1'b0;
    else cpu_req = 1'b0;
    @(negedge clk);
    check($sformatf("%s_ack_pulse", tag), v.dma ? dma_ack : cpu_ack, 0);
    check($sformatf("%s_idle", tag), busy, 0);
    check($sformatf("%s_addr_held", tag), dram_addr, v.addr);
    check($sformatf("%s_rdata_held", tag), v.dma ? dma_rdata : cpu_rdata,
          v.dma ? dma_rd_exp : cpu_rd_exp);
  endtask

  // Both sides raise a write in the same cycle; the winner acks at 2, the loser at 5.
  task automatic conflict_round(input bit exp_dma_first, input int r);
    int cpu_c, dma_c, cpu_n, dma_n;
    cpu_c = -1; dma_c = -1; cpu_n = 0; dma_n = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ADDR_W'(32'h100 + r); cpu_wdata = DATA_W'(32'h40 + r);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = ADDR_W'(32'h200 + r); dma_wdata = DATA_W'(32'h80 + r);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cpu_n++;
        if (cpu_c < 0) begin cpu_c = c; cpu_req = 1'b0; grant_log.push_back(1'b0); end
      end
      if (dma_ack) begin
        dma_n++;
        if (dma_c < 0) begin dma_c = c; dma_req = 1'b0; grant_log.push_back(1'b1); end
      end
    end
    check($sformatf("conflict%0d_cpu_acks", r), cpu_n, 1);
    check($sformatf("conflict%0d_dma_acks", r), dma_n, 1);
    check($sformatf("conflict%0d_cpu_cycle", r), cpu_c, exp_dma_first ? 5 : 2);
    check($sformatf("conflict%0d_dma_cycle", r), dma_c, exp_dma_first ? 2 : 5);
  endtask

  initial begin
    int c1, c2, cd, ncpu, ndma;
    logic [DATA_W-1:0] rd1, rd2;
    vec_t pre;

    vecs[0] = '{dma: 1'b0, we: 1'b1, addr: 17'h00010, wdata: 8'hA5, rdata: 8'h00};
    vecs[1] = '{dma: 1'b0, we: 1'b0, addr: 17'h00010, wdata: 8'h00, rdata: 8'hA5};
    vecs[2] = '{dma: 1'b1, we: 1'b1, addr: 17'h1FFFF, wdata: 8'h3C, rdata: 8'h00};
    vecs[3] = '{dma: 1'b1, we: 1'b0, addr: 17'h1FFFF, wdata: 8'h00, rdata: 8'h3C};
    vecs[4] = '{dma: 1'b0, we: 1'b1, addr: 17'h00000, wdata: 8'h5A, rdata: 8'h00};
    vecs[5] = '{dma: 1'b1, we: 1'b0, addr: 17'h00000, wdata: 8'h00, rdata: 8'h5A};
    vecs[6] = '{dma: 1'b0, we: 1'b0, addr: 17'h1FFFF, wdata: 8'h00, rdata: 8'h3C};
    vecs[7] = '{dma: 1'b1, we: 1'b1, addr: 17'h0AAAA, wdata: 8'hFF, rdata: 8'h00};
    vecs[8] = '{dma: 1'b0, we: 1'b0, addr: 17'h0AAAA, wdata: 8'h00, rdata: 8'hFF};

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 9; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests after reset alternate CPU, DMA, CPU, DMA ...
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 4; r++) conflict_round(1'b0, r);
    check("rr_log_size", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("rr_grant%0d", i), grant_log[i], i % 2);

    // DMA write slips in between back-to-back CPU reads of the same address
    pre = '{dma: 1'b0, we: 1'b1, addr: 17'h1FFFF, wdata: 8'h11, rdata: 8'h00};
    run_single(pre, "pre_fill");
    c1 = -1; c2 = -1; cd = -1; ncpu = 0; ndma = 0; rd1 = '0; rd2 = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h1FFFF; cpu_wdata = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        ncpu++;
        if (c1 < 0) begin c1 = c; rd1 = cpu_rdata; end
        else if (c2 < 0) begin c2 = c; rd2 = cpu_rdata; cpu_req = 1'b0; end
      end
      if (dma_ack) begin ndma++; cd = c; dma_req = 1'b0; end
      if (c == 1) begin
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 17'h1FFFF; dma_wdata = 8'h3C;
      end
    end
    check("cont_cpu1_cycle", c1, 3);
    check("cont_cpu1_rdata", rd1, 8'h11);
    check("cont_dma_cycle", cd, 6);
    check("cont_cpu2_cycle", c2, 10);
    check("cont_cpu2_rdata", rd2, 8'h3C);
    check("cont_cpu_acks", ncpu, 2);
    check("cont_dma_acks", ndma, 1);
    cpu_rd_exp = 8'h3C;

    // Reset lands in the WAIT state of a DMA read
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 17'h1FFFF; dma_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wait_busy", busy, 1);
    check("rst_wait_owner", owner_dma, 1);
    check("rst_wait_we", dram_we, 0);
    reset = 1'b0;
    dma_req = 1'b0;
    #1;
    check_all_zero("rst_async");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_no_ack%0d", c), dma_ack, 0);
    end
    reset = 1'b1;
    cpu_rd_exp = '0;
    dma_rd_exp = '0;
    pre = '{dma: 1'b1, we: 1'b0, addr: 17'h1FFFF, wdata: 8'h00, rdata: 8'h3C};
    run_single(pre, "rst_reissue");
    conflict_round(1'b0, 9);

    // Request fields changed and req dropped during ACCESS of a write, then of a read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00123; cpu_wdata = 8'h77;
    @(negedge clk);
    check("chg_w_we", dram_we, 1);
    check("chg_w_addr", dram_addr, 17'h00123);
    cpu_addr = 17'h00456; cpu_wdata = 8'h99; cpu_we = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("chg_w_ack", cpu_ack, 1);
    check("chg_w_addr_done", dram_addr, 17'h00123);
    check("chg_w_we_done", dram_we, 0);
    @(negedge clk);
    check("chg_w_ack_pulse", cpu_ack, 0);
    check("chg_w_idle_din", dram_din, 8'h77);
    check("chg_w_mem", mem[17'h00123], 8'h77);

    c1 = -1; ncpu = 0; rd1 = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00123; cpu_wdata = '0;
    @(negedge clk);
    check("chg_r_addr", dram_addr, 17'h00123);
    cpu_addr = 17'h1FFFF; cpu_req = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (cpu_ack) begin ncpu++; c1 = c; rd1 = cpu_rdata; end
    end
    check("chg_r_cycle", c1, 2 + RD_LAT);
    check("chg_r_acks", ncpu, 1);
    check("chg_r_rdata", rd1, 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
